// File: rtl/adc_pwr_sched.sv
// ---------------------------------------------------------------------------
// adc_pwr_sched
//
// Per-channel power integrator for a 4-channel signed ADC stream. Every valid
// sample is squared and accumulated per channel over a window of 2^N samples.
// At the end of a window the four sums are copied into shadow registers and
// drained as four ready/valid beats (ch0..ch3). A new window is accumulated
// while the previous one drains. If a window completes while its predecessor
// is still draining, the new results are dropped and the sticky overrun flag
// is set.
//
// Ports
//   user_clk       : single clock, rising edge
//   user_rst       : asynchronous active-high reset
//   ctrl_en        : enable integration
//   ctrl_win_log2  : log2 of window length, clamped to [4,16] when latched
//   ctrl_clr_ovr   : one-cycle pulse clearing the overrun flag
//   adc_valid      : adc_data holds one sample per channel this cycle
//   adc_data       : four signed samples, ch0 in the lowest byte
//   out_data       : sum of squares for out_chan
//   out_chan       : channel index of the current beat
//   out_valid      : beat available
//   out_ready      : downstream accepts the beat
//   out_last       : marks the ch3 beat
//   win_count      : completed-window counter (wraps)
//   overrun        : sticky, a window's results were dropped
// ---------------------------------------------------------------------------
module adc_pwr_sched #(
  parameter int NCH   = 4,
  parameter int ADC_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 ctrl_en,
  input  logic [4:0]           ctrl_win_log2,
  input  logic                 ctrl_clr_ovr,
  input  logic                 adc_valid,
  input  logic [NCH*ADC_W-1:0] adc_data,
  output logic [ACC_W-1:0]     out_data,
  output logic [1:0]           out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [15:0]          win_count,
  output logic                 overrun
);

  // Sample counter must reach 2^16, so it needs 17 bits.
  localparam int CNT_W = 17;

  typedef enum logic {IDLE, ACCUM} acc_state_t;
  typedef enum logic {EMPTY, DRAIN} drain_state_t;

  acc_state_t                acc_state;
  drain_state_t              drain_state;
  logic [4:0]                win_log2;
  logic [CNT_W-1:0]          sample_cnt;
  logic [ACC_W-1:0]          acc     [NCH];
  logic [ACC_W-1:0]          acc_sum [NCH];
  logic [ACC_W-1:0]          shadow  [NCH];
  logic signed [2*ADC_W-1:0] prod    [NCH];

  logic       last_sample;
  logic       window_done;
  logic       beat_xfer;
  logic       final_xfer;
  logic       shadow_load;
  logic       overrun_evt;
  logic [1:0] next_chan;

  // Window length is restricted to 16..65536 samples; anything outside that
  // range is pulled to the nearest end.
  function automatic logic [4:0] clamp_log2(input logic [4:0] v);
    if (v < 5'd4)
      return 5'd4;
    else if (v > 5'd16)
      return 5'd16;
    else
      return v;
  endfunction

  // Square of each signed sample plus the running accumulator. A signed
  // square is never negative and is at most 128^2, so the full product
  // zero-extends cleanly into the accumulator width.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      prod[c]    = $signed(adc_data[c*ADC_W +: ADC_W]) * $signed(adc_data[c*ADC_W +: ADC_W]);
      acc_sum[c] = acc[c] + ACC_W'($unsigned(prod[c]));
    end
  end

  // Window completes on the sample that brings the count to 2^N. The shadow
  // may be reloaded either when the drain side is empty or when the ch3 beat
  // leaves on this very edge, which lets windows run back to back.
  always_comb begin
    last_sample = (sample_cnt == ((CNT_W'(1) << win_log2) - CNT_W'(1)));
    window_done = (acc_state == ACCUM) && ctrl_en && adc_valid && last_sample;
    beat_xfer   = out_valid && out_ready;
    final_xfer  = beat_xfer && (out_chan == 2'd3);
    shadow_load = window_done && ((drain_state == EMPTY) || final_xfer);
    overrun_evt = window_done && !shadow_load;
    next_chan   = out_chan + 2'd1;
  end

  // Integration FSM: accumulates squares while enabled. Dropping enable
  // throws away the partial window; completing a window clears the sums and
  // re-latches the window length so the next window starts immediately.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      acc_state  <= IDLE;
      win_log2   <= 5'd4;
      sample_cnt <= '0;
      win_count  <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      case (acc_state)
        IDLE: begin
          if (ctrl_en) begin
            acc_state <= ACCUM;
            win_log2  <= clamp_log2(ctrl_win_log2);
          end
        end
        ACCUM: begin
          if (!ctrl_en) begin
            acc_state  <= IDLE;
            sample_cnt <= '0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
          end else if (adc_valid) begin
            if (last_sample) begin
              sample_cnt <= '0;
              win_count  <= win_count + 16'd1;
              win_log2   <= clamp_log2(ctrl_win_log2);
              for (int c = 0; c < NCH; c++) acc[c] <= '0;
            end else begin
              sample_cnt <= sample_cnt + CNT_W'(1);
              for (int c = 0; c < NCH; c++) acc[c] <= acc_sum[c];
            end
          end
        end
        default: acc_state <= IDLE;
      endcase
    end
  end

  // Drain FSM: presents the shadow sums one channel per beat. Output
  // registers only change on a load or an accepted beat, so they hold steady
  // under backpressure and keep their last values once the drain is empty.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      drain_state <= EMPTY;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      out_chan    <= 2'd0;
      for (int c = 0; c < NCH; c++) shadow[c] <= '0;
    end else begin
      case (drain_state)
        EMPTY: begin
          if (shadow_load) begin
            for (int c = 0; c < NCH; c++) shadow[c] <= acc_sum[c];
            drain_state <= DRAIN;
            out_valid   <= 1'b1;
            out_data    <= acc_sum[0];
            out_chan    <= 2'd0;
            out_last    <= 1'b0;
          end
        end
        DRAIN: begin
          if (shadow_load) begin
            for (int c = 0; c < NCH; c++) shadow[c] <= acc_sum[c];
            out_valid <= 1'b1;
            out_data  <= acc_sum[0];
            out_chan  <= 2'd0;
            out_last  <= 1'b0;
          end else if (beat_xfer) begin
            if (out_chan == 2'd3) begin
              drain_state <= EMPTY;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
            end else begin
              out_chan <= next_chan;
              out_data <= shadow[next_chan];
              out_last <= (next_chan == 2'd3);
            end
          end
        end
        default: drain_state <= EMPTY;
      endcase
    end
  end

  // Sticky overrun flag; a new drop on the same edge as a clear wins so that
  // no lost window can go unreported.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst)
      overrun <= 1'b0;
    else if (overrun_evt)
      overrun <= 1'b1;
    else if (ctrl_clr_ovr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_adc_pwr_sched.sv
// ---------------------------------------------------------------------------
// tb_adc_pwr_sched
//
// Self-checking bench for adc_pwr_sched. A behavioural model tracks window
// sums, pending drain results and counters with plain integers; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations for key results.
// ---------------------------------------------------------------------------
module tb_adc_pwr_sched;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b0;
  logic        ctrl_en;
  logic [4:0]  ctrl_win_log2;
  logic        ctrl_clr_ovr;
  logic        adc_valid;
  logic [31:0] adc_data;
  logic [31:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] win_count;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  bit          m_active = 1'b0;
  int          m_len = 16;
  int          m_cnt = 0;
  logic [63:0] m_sum [4] = '{default: '0};
  bit          m_busy = 1'b0;
  int          m_beat = 0;
  logic [63:0] m_res [4] = '{default: '0};
  logic [15:0] m_wins = '0;
  bit          m_ovr = 1'b0;
  bit          m_evt = 1'b0;
  logic [31:0] m_beats [$];

  always #5 user_clk = ~user_clk;

  adc_pwr_sched dut (
    .user_clk      (user_clk),
    .user_rst      (user_rst),
    .ctrl_en       (ctrl_en),
    .ctrl_win_log2 (ctrl_win_log2),
    .ctrl_clr_ovr  (ctrl_clr_ovr),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .out_data      (out_data),
    .out_chan      (out_chan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .win_count     (win_count),
    .overrun       (overrun)
  );

  function automatic int clamp_len(input logic [4:0] v);
    int n;
    n = int'(v);
    if (n < 4) n = 4;
    if (n > 16) n = 16;
    return 1 << n;
  endfunction

  function automatic logic [63:0] square_of(input logic [31:0] d, input int c);
    int s;
    s = int'($signed(d[8*c +: 8]));
    return 64'(s * s);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: window sums and a list of pending results, advanced at each rising
  // edge from the same inputs the DUT sees. A finishing drain frees the
  // result slot before a completing window looks for room.
  always @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      m_active = 1'b0;
      m_len    = 16;
      m_cnt    = 0;
      m_busy   = 1'b0;
      m_beat   = 0;
      m_wins   = '0;
      m_ovr    = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_sum[c] = '0;
        m_res[c] = '0;
      end
    end else begin
      m_evt = 1'b0;
      if (m_busy && out_ready) begin
        m_beats.push_back(m_res[m_beat][31:0]);
        if (m_beat == 3) m_busy = 1'b0;
        else m_beat++;
      end
      if (!m_active) begin
        if (ctrl_en) begin
          m_active = 1'b1;
          m_len    = clamp_len(ctrl_win_log2);
        end
      end else if (!ctrl_en) begin
        m_active = 1'b0;
        m_cnt    = 0;
        for (int c = 0; c < 4; c++) m_sum[c] = '0;
      end else if (adc_valid) begin
        for (int c = 0; c < 4; c++) m_sum[c] = m_sum[c] + square_of(adc_data, c);
        m_cnt++;
        if (m_cnt == m_len) begin
          m_wins = m_wins + 16'd1;
          if (!m_busy) begin
            for (int c = 0; c < 4; c++) m_res[c] = m_sum[c];
            m_busy = 1'b1;
            m_beat = 0;
          end else begin
            m_evt = 1'b1;
          end
          for (int c = 0; c < 4; c++) m_sum[c] = '0;
          m_cnt = 0;
          m_len = clamp_len(ctrl_win_log2);
        end
      end
      if (m_evt) m_ovr = 1'b1;
      else if (ctrl_clr_ovr) m_ovr = 1'b0;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge user_clk) begin
    if (cmp_en && !user_rst) begin
      checkOutput("out_valid", out_valid, m_busy);
      checkOutput("out_chan", out_chan, 64'(m_beat));
      checkOutput("out_data", out_data, m_res[m_beat]);
      checkOutput("out_last", out_last, (m_busy && m_beat == 3));
      checkOutput("win_count", win_count, m_wins);
      checkOutput("overrun", overrun, m_ovr);
    end
  end

  // One cycle of stimulus, applied just after the falling edge.
  task automatic applyStimulus(input logic en, input logic [4:0] wl, input logic vld,
                               input logic [31:0] data, input logic rdy, input logic clr);
    @(negedge user_clk);
    #1;
    ctrl_en       = en;
    ctrl_win_log2 = wl;
    adc_valid     = vld;
    adc_data      = data;
    out_ready     = rdy;
    ctrl_clr_ovr  = clr;
  endtask

  task automatic doReset();
    @(negedge user_clk);
    #2;
    user_rst     = 1'b1;
    ctrl_en      = 1'b0;
    adc_valid    = 1'b0;
    out_ready    = 1'b1;
    ctrl_clr_ovr = 1'b0;
    @(negedge user_clk);
    #2;
    user_rst = 1'b0;
  endtask

  int base;

  initial begin
    ctrl_en = 0; ctrl_win_log2 = 5'd4; ctrl_clr_ovr = 0;
    adc_valid = 0; adc_data = '0; out_ready = 1;
    #1 user_rst = 1'b1;
    #3;
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_chan", out_chan, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_win_count", win_count, 0);
    checkOutput("rst_overrun", overrun, 0);
    @(negedge user_clk);
    #2 user_rst = 1'b0;
    cmp_en = 1'b1;

    // Basic window of 16 with mixed sign samples.
    $display("[TB] scenario: basic window");
    doReset();
    base = m_beats.size();
    applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    repeat (16) applyStimulus(1, 5'd4, 1, 32'h807FFF01, 1, 0);
    repeat (6) applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    checkOutput("basic_nbeats", m_beats.size() - base, 4);
    checkOutput("basic_beat0", m_beats[base+0], 16);
    checkOutput("basic_beat1", m_beats[base+1], 16);
    checkOutput("basic_beat2", m_beats[base+2], 258064);
    checkOutput("basic_beat3", m_beats[base+3], 262144);
    checkOutput("basic_win_count", win_count, 1);
    checkOutput("basic_hold_data", out_data, 262144);

    // Window length below the minimum is clamped to 16.
    $display("[TB] scenario: clamp");
    doReset();
    applyStimulus(1, 5'd2, 0, 32'h0, 1, 0);
    repeat (4) applyStimulus(1, 5'd2, 1, 32'h01010101, 1, 0);
    applyStimulus(1, 5'd2, 0, 32'h0, 1, 0);
    checkOutput("clamp_after4", out_valid, 0);
    repeat (11) applyStimulus(1, 5'd2, 1, 32'h01010101, 1, 0);
    applyStimulus(1, 5'd2, 0, 32'h0, 1, 0);
    checkOutput("clamp_after15", out_valid, 0);
    applyStimulus(1, 5'd2, 1, 32'h01010101, 1, 0);
    applyStimulus(1, 5'd2, 0, 32'h0, 1, 0);
    checkOutput("clamp_after16", out_valid, 1);
    checkOutput("clamp_data", out_data, 16);
    repeat (6) applyStimulus(1, 5'd2, 0, 32'h0, 1, 0);

    // Backpressure across two windows produces an overrun.
    $display("[TB] scenario: overrun");
    doReset();
    base = m_beats.size();
    applyStimulus(1, 5'd4, 0, 32'h0, 0, 0);
    repeat (16) applyStimulus(1, 5'd4, 1, 32'h00000003, 0, 0);
    repeat (16) applyStimulus(1, 5'd4, 1, 32'h00000005, 0, 0);
    repeat (2) applyStimulus(1, 5'd4, 0, 32'h0, 0, 0);
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_win_count", win_count, 2);
    checkOutput("ovr_hold_data", out_data, 144);
    checkOutput("ovr_hold_chan", out_chan, 0);
    applyStimulus(1, 5'd4, 0, 32'h0, 0, 1);
    applyStimulus(1, 5'd4, 0, 32'h0, 0, 0);
    checkOutput("ovr_cleared", overrun, 0);
    repeat (6) applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    checkOutput("ovr_nbeats", m_beats.size() - base, 4);
    checkOutput("ovr_beat0", m_beats[base+0], 144);
    checkOutput("ovr_beat1", m_beats[base+1], 0);

    // Disabling mid-window discards the partial sums.
    $display("[TB] scenario: disable mid-window");
    doReset();
    base = m_beats.size();
    applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    repeat (7) applyStimulus(1, 5'd4, 1, 32'h05050505, 1, 0);
    repeat (2) applyStimulus(0, 5'd4, 0, 32'h0, 1, 0);
    applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    repeat (16) applyStimulus(1, 5'd4, 1, 32'h02020202, 1, 0);
    repeat (6) applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    checkOutput("dis_nbeats", m_beats.size() - base, 4);
    checkOutput("dis_beat0", m_beats[base+0], 64);
    checkOutput("dis_beat3", m_beats[base+3], 64);
    checkOutput("dis_win_count", win_count, 1);

    // Asynchronous reset in the middle of a drain.
    $display("[TB] scenario: reset mid-drain");
    doReset();
    base = m_beats.size();
    applyStimulus(1, 5'd4, 0, 32'h0, 0, 0);
    repeat (16) applyStimulus(1, 5'd4, 1, 32'h01010101, 0, 0);
    repeat (2) applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    applyStimulus(1, 5'd4, 0, 32'h0, 0, 0);
    checkOutput("mid_chan", out_chan, 2);
    checkOutput("mid_valid", out_valid, 1);
    #1 user_rst = 1'b1;
    #1;
    checkOutput("arst_valid", out_valid, 0);
    checkOutput("arst_data", out_data, 0);
    checkOutput("arst_chan", out_chan, 0);
    checkOutput("arst_last", out_last, 0);
    checkOutput("arst_win_count", win_count, 0);
    @(negedge user_clk);
    #2 user_rst = 1'b0;
    applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    repeat (8) applyStimulus(1, 5'd4, 1, 32'h01010101, 1, 0);
    repeat (3) applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    checkOutput("arst_no_beats", m_beats.size() - base, 2);
    checkOutput("arst_idle_valid", out_valid, 0);

    // Maximum window of full-scale negative samples, then back-to-back
    // windows of 16 with continuous input.
    $display("[TB] scenario: max window and back-to-back");
    doReset();
    base = m_beats.size();
    applyStimulus(1, 5'd16, 0, 32'h0, 1, 0);
    repeat (65536 + 48) applyStimulus(1, 5'd4, 1, 32'h80808080, 1, 0);
    repeat (6) applyStimulus(1, 5'd4, 0, 32'h0, 1, 0);
    checkOutput("max_nbeats", m_beats.size() - base, 16);
    checkOutput("max_beat0", m_beats[base+0], 32'h40000000);
    checkOutput("max_beat3", m_beats[base+3], 32'h40000000);
    checkOutput("b2b_beat4", m_beats[base+4], 262144);
    checkOutput("b2b_beat15", m_beats[base+15], 262144);
    checkOutput("b2b_overrun", overrun, 0);
    checkOutput("b2b_win_count", win_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_pwr_sched.md
ADC_PWR_SCHED -- requirements
Module: adc_pwr_sched

Interface
REQ-001 Parameter: NCH, 4, number of ADC channels (fixed; other values unsupported).
REQ-002 Parameter: ADC_W, 8, signed sample width per channel.
REQ-003 Parameter: ACC_W, 32, accumulator and output word width.
REQ-004 Port: user_clk  in  1  single clock; all logic on its rising edge.
REQ-005 Port: user_rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: ctrl_en  in  1  enable integration (software register bit).
REQ-007 Port: ctrl_win_log2  in  5  log2 of window length in samples.
REQ-008 Port: ctrl_clr_ovr  in  1  one-cycle pulse, clears overrun.
REQ-009 Port: adc_valid  in  1  adc_data carries one sample per channel this cycle.
REQ-010 Port: adc_data  in  32  four signed 8-bit samples; ch0 in [7:0], ch3 in [31:24].
REQ-011 Port: out_data  out  32  sum of squares for out_chan.
REQ-012 Port: out_chan  out  2  channel index of out_data.
REQ-013 Port: out_valid  out  1  beat available.
REQ-014 Port: out_ready  in  1  downstream accepts beat.
REQ-015 Port: out_last  out  1  high on the ch3 beat.
REQ-016 Port: win_count  out  16  completed-window counter, wraps 0xFFFF->0x0000.
REQ-017 Port: overrun  out  1  sticky: a window's results were dropped.

Function
REQ-018 Integration FSM SHALL have states IDLE and ACCUM.
REQ-019 IDLE->ACCUM on a clock edge with ctrl_en=1; ctrl_win_log2 latched, clamped to [4,16].
REQ-020 In ACCUM, each adc_valid=1 cycle SHALL add sample^2 (signed square, 15-bit unsigned result) to acc[c] for all four channels and increment the sample counter; adc_valid=0 cycles change nothing.
REQ-021 Window completes on the edge accepting sample number 2^N (N = latched value): the shadow registers SHALL load acc+current square, acc and counter clear, win_count increments, ctrl_win_log2 re-latched; no sample is lost between windows.
REQ-022 Sums SHALL be exact, no saturation (max 16384*65536 = 0x40000000).
REQ-023 ctrl_en=0 in ACCUM: next edge ->IDLE, acc and counter cleared, partial window discarded, win_count unchanged; any drain in progress completes normally.
REQ-024 Drain FSM states EMPTY and DRAIN; shadow load sets DRAIN with ch=0; out_valid=1 from the cycle after the window-completing edge.
REQ-025 In DRAIN: out_data=shadow[ch], out_chan=ch, out_last=(ch==3); beat transfers when out_valid&out_ready; ch increments; beat with ch=3 returns to EMPTY.
REQ-026 out_data, out_chan, out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Window completion on the same edge as the ch3 beat transfer SHALL load shadow and remain in DRAIN with ch=0, no bubble.
REQ-028 Window completion while DRAIN and not REQ-027: new results dropped, shadow unchanged, overrun<=1, win_count still increments.
REQ-029 ctrl_clr_ovr clears overrun; simultaneous new overrun event wins (overrun=1).
REQ-030 In EMPTY, out_valid=0, out_last=0; out_data/out_chan hold last values.

Reset
REQ-031 user_rst=1 SHALL immediately force IDLE, EMPTY, acc/shadow/counter=0, out_data=0, out_chan=0, out_valid=0, out_last=0, win_count=0, overrun=0, latched win_log2=4.
REQ-032 Reset mid-window or mid-drain SHALL discard all data; after release, operation restarts per REQ-019.

Verification
REQ-033 win_log2=4, constant ch0=1, ch1=-1, ch2=127, ch3=-128, 16 valid samples, out_ready=1 -> beats 16, 16, 258064, 262144 on chans 0..3, out_last on 4th, win_count=1.
REQ-034 win_log2=2 -> clamped: no output after 4 or 15 samples, first beats after sample 16.
REQ-035 out_ready=0 through two windows -> first window's ch0 held stable, overrun=1, win_count=2, second window data never appears; ctrl_clr_ovr pulse -> overrun=0.
REQ-036 ctrl_en dropped after 7 samples, re-enabled, 16 samples of value 2 -> single drain of 64 per channel, win_count=1.
REQ-037 user_rst pulsed mid-drain (ch=2) -> outputs zero asynchronously without a clock edge; no further beats after release until a full new window.
REQ-038 win_log2=16, all samples -128, continuous valid -> out_data=0x40000000 every channel; back-to-back windows with out_ready=1 -> no overrun.
